// File: rtl/bitwise_logic_serial_pkg.sv
// bitwise_logic_serial_pkg: op and FSM state encodings shared by the serial logic unit.
package bitwise_logic_serial_pkg;
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/bitwise_logic_serial_logic_slice.sv
// logic_slice: combinational SLICE-wide AND/OR/XOR/NOR unit.
module logic_slice
    import bitwise_logic_serial_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  op_e              op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);
    always_comb
        y = op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_XOR ? a ^ b : ~(a | b);
endmodule

// File: rtl/bitwise_logic_serial.sv
// bitwise_logic_serial: multi-cycle bitwise unit, one SLICE-bit chunk per clock with start/busy/done.
// Define BLS_ZERO_FLAG_EN to add the registered zero flag output.
module bitwise_logic_serial
    import bitwise_logic_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Output
`ifdef BLS_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = NSLICE > 1 ? $clog2(NSLICE) : 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic [SLICE-1:0] a_sl, b_sl, y;
    int               base;

    // acc_d already holds slice k so the final edge can load Output with it.
    always_comb begin
        base  = int'(cnt_q) * SLICE;
        a_sl  = a_q[base +: SLICE];
        b_sl  = b_q[base +: SLICE];
        acc_d = acc_q;
        acc_d[base +: SLICE] = y;
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .a  (a_sl),
        .b  (b_sl),
        .y  (y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Output  <= '0;
`ifdef BLS_ZERO_FLAG_EN
            zero    <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    a_q     <= input1;
                    b_q     <= input2;
                    op_q    <= op_e'(op);
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    busy    <= 1'b1;
                    state_q <= RUN;
                end
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(NSLICE - 1)) begin
                    Output  <= acc_d;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
`ifdef BLS_ZERO_FLAG_EN
                    zero    <= acc_d == '0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_bitwise_logic_serial.sv
// tb_bitwise_logic_serial: randomized and directed checks of the serial logic unit against an arithmetic model.
module tb_bitwise_logic_serial;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] input1 = '0, input2 = '0;
    logic        busy, done;
    logic [31:0] out;
    logic        start8 = 1'b0, busy8, done8;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0, out8;
    logic        start64 = 1'b0, busy64, done64;
    logic [1:0]  op64 = 2'b00;
    logic [63:0] a64 = '0, b64 = '0, out64;
`ifdef BLS_ZERO_FLAG_EN
    logic        zero, zero8, zero64;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bitwise_logic_serial #(.WIDTH(32), .SLICE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .input1(input1), .input2(input2),
        .busy(busy), .done(done), .Output(out)
`ifdef BLS_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    bitwise_logic_serial #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .input1(a8), .input2(b8),
        .busy(busy8), .done(done8), .Output(out8)
`ifdef BLS_ZERO_FLAG_EN
        , .zero(zero8)
`endif
    );

    bitwise_logic_serial #(.WIDTH(64), .SLICE(4)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .op(op64), .input1(a64), .input2(b64),
        .busy(busy64), .done(done64), .Output(out64)
`ifdef BLS_ZERO_FLAG_EN
        , .zero(zero64)
`endif
    );

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; input1 = a; input2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles from the accept edge to done; steady records busy high and Output held meanwhile.
    task automatic wait_done(input int inject_at, output int cyc, output bit steady);
        logic [31:0] prev;
        prev = out; steady = 1'b1; cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin cyc = c; break; end
            if (!busy || out !== prev) steady = 1'b0;
            if (c == inject_at) begin
                start = 1'b1; op = 2'b01; input1 = 32'h1234_5678; input2 = 32'hCAFE_0000;
            end else start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
            failures++; $display("FAIL reset_state busy=%b done=%b out=%h required 0 0 0", busy, done, out);
        end
        checks++;
        if (busy8 !== 1'b0 || out8 !== 8'h0 || busy64 !== 1'b0 || out64 !== 64'h0) begin
            failures++; $display("FAIL reset_state_widths out8=%h out64=%h required 0", out8, out64);
        end
`ifdef BLS_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b required 1", zero); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_directed;
        int cyc; bit steady;
        logic [1:0]  ops [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
        logic [31:0] as  [4] = '{32'hFFFF0000, 32'h12345678, 32'h0, 32'hA5A5A5A5};
        logic [31:0] bs  [4] = '{32'h0F0F0F0F, 32'h80000001, 32'h0, 32'hA5A5A5A5};
        logic [31:0] exp [4] = '{32'h0F0F0000, 32'h92345679, 32'hFFFFFFFF, 32'h0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(-1, cyc, steady);
            checks++;
            if (cyc !== 8) begin failures++; $display("FAIL directed_latency[%0d] got=%0d required 8", i, cyc); end
            checks++;
            if (!steady) begin failures++; $display("FAIL directed_hold[%0d] busy or Output changed before done", i); end
            checks++;
            if (out !== exp[i]) begin failures++; $display("FAIL directed_out[%0d] got=%h required %h", i, out, exp[i]); end
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL directed_busy_done[%0d] got=%b required 0", i, busy); end
`ifdef BLS_ZERO_FLAG_EN
            checks++;
            if (zero !== (exp[i] == 0)) begin failures++; $display("FAIL directed_zero[%0d] got=%b required %b", i, zero, exp[i] == 0); end
`endif
        end
    endtask

    task automatic test_random;
        int cyc; bit steady;
        logic [1:0] o; logic [31:0] a, b, e;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            if (i % 6 == 5) b = a;
            e = 32'(model(o, {32'h0, a}, {32'h0, b}));
            issue(o, a, b);
            wait_done(-1, cyc, steady);
            checks++;
            if (cyc !== 8 || !steady || out !== e) begin
                failures++; $display("FAIL random[%0d] op=%0d cyc=%0d steady=%0b out=%h required cyc=8 out=%h", i, o, cyc, steady, out, e);
            end
`ifdef BLS_ZERO_FLAG_EN
            checks++;
            if (zero !== (e == 0)) begin failures++; $display("FAIL random_zero[%0d] got=%b required %b", i, zero, e == 0); end
`endif
        end
    endtask

    task automatic test_back_to_back;
        int cyc; bit steady;
        issue(2'd0, 32'hFFFFFFFF, 32'h000000FF);
        wait_done(2, cyc, steady);
        checks++;
        if (cyc !== 8 || out !== 32'h000000FF) begin
            failures++; $display("FAIL ignored_start cyc=%0d out=%h required 8 000000ff", cyc, out);
        end
        issue(2'd2, 32'hF0F0F0F0, 32'hFFFFFFFF);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_accept done=%b busy=%b required 0 1", done, busy);
        end
        wait_done(-1, cyc, steady);
        checks++;
        if (cyc !== 8 || !steady || out !== 32'h0F0F0F0F) begin
            failures++; $display("FAIL b2b_result cyc=%0d steady=%0b out=%h required 8 1 0f0f0f0f", cyc, steady, out);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_idle_after done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc; bit steady; bit saw_done;
        issue(2'd0, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_done(-1, cyc, steady);
        checks++;
        if (out !== 32'h0F0F0000) begin failures++; $display("FAIL abort_setup out=%h required 0f0f0000", out); end
        issue(2'd1, 32'h1, 32'h1);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
            failures++; $display("FAIL abort_state busy=%b done=%b out=%h required 0 0 0", busy, done, out);
        end
`ifdef BLS_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b1) begin failures++; $display("FAIL abort_zero got=%b required 1", zero); end
`endif
        saw_done = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
        checks++;
        if (saw_done) begin failures++; $display("FAIL abort_no_done got done/busy activity required none"); end
    endtask

    task automatic test_widths;
        int cyc;
        logic [63:0] e;
        op8 = 2'd0; a8 = 8'hF0; b8 = 8'h3C; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin failures++; $display("FAIL w8_busy got=%b required 1", busy8); end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b1 || out8 !== 8'h30 || busy8 !== 1'b0) begin
            failures++; $display("FAIL w8_and done=%b out=%h busy=%b required 1 30 0", done8, out8, busy8);
        end
        for (int i = 0; i < 4; i++) begin
            op64 = i == 0 ? 2'd2 : i == 1 ? 2'd0 : 2'($urandom_range(0, 3));
            a64  = i == 0 ? 64'hFFFFFFFFFFFFFFFF : i == 1 ? 64'hF0 : {$urandom, $urandom};
            b64  = i == 0 ? 64'h0123456789ABCDEF : i == 1 ? 64'h3C : {$urandom, $urandom};
            e = model(op64, a64, b64);
            start64 = 1'b1;
            @(posedge clk); #1;
            start64 = 1'b0;
            cyc = -1;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (done64) begin cyc = c; break; end
            end
            checks++;
            if (cyc !== 16 || out64 !== e) begin
                failures++; $display("FAIL w64[%0d] cyc=%0d out=%h required 16 %h", i, cyc, out64, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid_run;
        test_widths;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bitwise_logic_serial.md
Name: bitwise_logic_serial

Overview:
Parametrised, multi-cycle bitwise logic unit for the datapath ALU. It supersedes the fixed 32-bit, AND-only, purely combinational unit built from 4-bit slices. It processes a WIDTH-bit operand pair one SLICE-bit chunk per clock and supports four logic ops. A start/busy/done handshake lets the control unit stall while a result is built.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE
SLICE, 4, bits processed per cycle; NSLICE = WIDTH/SLICE, minimum 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR
input1  input  WIDTH  operand A
input2  input  WIDTH  operand B
busy  output  1  high while a request is in progress
done  output  1  one-cycle pulse: Output just updated
Output  output  WIDTH  registered result of the last completed request
zero  output  1  (only with BLS_ZERO_FLAG_EN) Output == 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset, sampled at the rising edge. It overrides all other inputs.
- Reset values:
  - state IDLE, slice counter 0, accumulator 0
  - busy 0, done 0, Output 0, zero 1
- States:
  - IDLE: if start=1, latch input1, input2 and op into internal registers, clear the accumulator, set counter=0, and go to RUN. busy=1 from the next cycle.
  - RUN: each cycle, write f(op, A[k], B[k]) into accumulator slice k, where k = counter and slices are taken LSB-first, then increment counter.
  - Leaving RUN: when counter = NSLICE-1, on the same edge load Output with the complete accumulator (including slice k), pulse done, clear busy, and return to IDLE.
- Latency:
  - done is high exactly NSLICE cycles after the edge that accepted start. That is 8 cycles for the defaults and 1 cycle when SLICE=WIDTH.
  - done lasts one cycle. Its cycle is IDLE, so start asserted in the done cycle is accepted (back-to-back issue, NSLICE+0 gap).
- Operands and op changing after acceptance have no effect.
- start while busy=1 is ignored, not queued.
- Output holds the previous result for the whole of RUN. It changes only on the done edge or on reset.
- Reset mid-RUN: abort the request, discard the partial accumulator, give no done pulse, and Output returns to 0.
- Counter width is clog2(NSLICE), minimum 1. There is no wrap-around: the counter resets on each accept.
- NOR is the bitwise complement of OR across all WIDTH bits.

Optional Feature:
- Macro BLS_ZERO_FLAG_EN.
  - Defined: port zero exists, as a register updated on the same edge as Output. It is 1 when the new Output is all zeros, and 1 at reset.
  - Undefined: port zero and its register are absent. All other behaviour is identical.

Decomposition:
- Shared include file bls_defs: the op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11, and the state encodings IDLE/RUN.
- One sub-module, logic_slice. It is a combinational SLICE-wide op unit (op, a, b -> y) and is instantiated once; the top muxes slice k into it.
- Top module: FSM, counter, operand/op latches, accumulator, Output/done/zero registers.

Test Plan:
- Reset, then AND: input1=0xFFFF0000, input2=0x0F0F0F0F, start 1 cycle. Required: busy=1 for 8 cycles; done pulses 8 cycles after accept; Output=0x0F0F0000; zero=0.
- OR 0x12345678|0x80000001 -> Output=0x92345679. XOR 0xA5A5A5A5^0xA5A5A5A5 -> Output=0x00000000 with zero=1. NOR 0^0 -> Output=0xFFFFFFFF.
- Start AND(0xFFFFFFFF,0x000000FF). At cycle 3 change operands and pulse start with op=OR. Required: second start ignored; Output=0x000000FF. Then start in the done cycle with XOR(0xF0F0F0F0,0xFFFFFFFF): Output=0x0F0F0F0F exactly 8 cycles later.
- Complete any op with Output=0x0F0F0000. Start a new request; assert reset at cycle 3 of RUN. Required: next cycle busy=0, Output=0, zero=1; no done pulse for the aborted request.
- Output holds 0x92345679 throughout a following NOR run and changes only on the done edge.
- Instances with WIDTH=8,SLICE=8 and WIDTH=64,SLICE=4: AND 0xF0&0x3C -> 0x30 with done 1 cycle after accept. For WIDTH=64, all-ones XOR 0x0123456789ABCDEF -> 0xFEDCBA9876543210 after 16 cycles.
